// File: rtl/sram_rr_arbiter.sv
// Round-robin sharing of one 1rw SRAM macro between two command requesters.
// Define SRAM_ARB_CLEAR_ON_RESET_EN to zero the whole macro after every reset.
module sram_rr_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [MASK_W-1:0] r0_wmask,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rsp_valid,
  output logic [DATA_W-1:0] r0_rsp_rdata,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [MASK_W-1:0] r1_wmask,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rsp_valid,
  output logic [DATA_W-1:0] r1_rsp_rdata,
  output logic              busy,
  output logic              ram_clk0,
  output logic              ram_csb0,
  output logic              ram_web0,
  output logic [MASK_W-1:0] ram_wmask0,
  output logic [ADDR_W-1:0] ram_addr0,
  output logic [DATA_W-1:0] ram_din0,
  input  logic [DATA_W-1:0] ram_dout0
);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t state;
  logic   last_grant;
  logic   rsp_valid;
  logic   rsp_owner;
  logic   arb_en;
  logic   grant0;
  logic   grant1;

`ifdef SRAM_ARB_CLEAR_ON_RESET_EN
  logic [ADDR_W-1:0] clr_addr;
  logic              clearing;
  assign clearing = rst_n && (state == CLEAR);
`endif

  // On a tie the requester that did not win last time is granted.
  assign arb_en = rst_n && (state == ARB);
  assign grant0 = arb_en && r0_valid && (!r1_valid || last_grant);
  assign grant1 = arb_en && r1_valid && (!r0_valid || !last_grant);

  assign r0_ready = grant0;
  assign r1_ready = grant1;
  assign busy     = !arb_en;
  assign ram_clk0 = clk;

  assign r0_rsp_valid = rst_n && rsp_valid && !rsp_owner;
  assign r1_rsp_valid = rst_n && rsp_valid && rsp_owner;
  assign r0_rsp_rdata = r0_rsp_valid ? ram_dout0 : '0;
  assign r1_rsp_rdata = r1_rsp_valid ? ram_dout0 : '0;

  always_comb begin
    ram_csb0   = 1'b1;
    ram_web0   = 1'b0;
    ram_wmask0 = '0;
    ram_addr0  = '0;
    ram_din0   = '0;
    if (grant0) begin
      ram_csb0   = 1'b0;
      ram_web0   = !r0_we;
      ram_wmask0 = r0_we ? r0_wmask : '0;
      ram_addr0  = r0_addr;
      ram_din0   = r0_wdata;
    end else if (grant1) begin
      ram_csb0   = 1'b0;
      ram_web0   = !r1_we;
      ram_wmask0 = r1_we ? r1_wmask : '0;
      ram_addr0  = r1_addr;
      ram_din0   = r1_wdata;
    end
`ifdef SRAM_ARB_CLEAR_ON_RESET_EN
    if (clearing) begin
      ram_csb0   = 1'b0;
      ram_web0   = 1'b0;
      ram_wmask0 = '1;
      ram_addr0  = clr_addr;
      ram_din0   = '0;
    end
`endif
  end

  // The response register remembers which requester owns next cycle's read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_owner  <= 1'b0;
`ifdef SRAM_ARB_CLEAR_ON_RESET_EN
      state      <= CLEAR;
      clr_addr   <= '0;
`else
      state      <= ARB;
`endif
    end else begin
      if (grant0) begin
        last_grant <= 1'b0;
      end else if (grant1) begin
        last_grant <= 1'b1;
      end
      rsp_valid <= (grant0 && !r0_we) || (grant1 && !r1_we);
      rsp_owner <= grant1;
`ifdef SRAM_ARB_CLEAR_ON_RESET_EN
      if (state == CLEAR) begin
        clr_addr <= clr_addr + 1'b1;
        if (clr_addr == '1) begin
          state <= ARB;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with a behavioural 512x32 1rw macro model.
// Clear-on-reset checks are built when SRAM_ARB_CLEAR_ON_RESET_EN is defined.
`timescale 1ns/1ps
module tb_sram_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r0_we, r1_valid, r1_we;
  logic [8:0]  r0_addr, r1_addr;
  logic [3:0]  r0_wmask, r1_wmask;
  logic [31:0] r0_wdata, r1_wdata;
  logic        r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid;
  logic [31:0] r0_rsp_rdata, r1_rsp_rdata;
  logic        busy, ram_clk0, ram_csb0, ram_web0;
  logic [3:0]  ram_wmask0;
  logic [8:0]  ram_addr0;
  logic [31:0] ram_din0, ram_dout0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:511];
  bit          model_init;

  always #5 clk = ~clk;

  sram_rr_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wmask(r0_wmask), .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid),
    .r0_rsp_rdata(r0_rsp_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wmask(r1_wmask), .r1_wdata(r1_wdata), .r1_rsp_valid(r1_rsp_valid),
    .r1_rsp_rdata(r1_rsp_rdata),
    .busy(busy), .ram_clk0(ram_clk0), .ram_csb0(ram_csb0), .ram_web0(ram_web0),
    .ram_wmask0(ram_wmask0), .ram_addr0(ram_addr0), .ram_din0(ram_din0),
    .ram_dout0(ram_dout0)
  );

  // Macro model: preloaded with a per-address pattern so reads are distinguishable.
  always @(posedge ram_clk0) begin
    if (!model_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hC0DE0000 + i;
      model_init <= 1'b1;
    end else if (!ram_csb0) begin
      if (!ram_web0) begin
        for (int b = 0; b < 4; b++)
          if (ram_wmask0[b]) mem[ram_addr0][b*8 +: 8] <= ram_din0[b*8 +: 8];
      end else begin
        ram_dout0 <= mem[ram_addr0];
      end
    end
  end

  task automatic set_idle;
    r0_valid = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wmask = '0; r0_wdata = '0;
    r1_valid = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wmask = '0; r1_wdata = '0;
  endtask

  task automatic r0_cycle(input logic we, input logic [8:0] addr,
                          input logic [3:0] wmask, input logic [31:0] wdata);
    r0_valid = 1'b1; r0_we = we; r0_addr = addr; r0_wmask = wmask; r0_wdata = wdata;
    @(posedge clk); #1;
    r0_valid = 1'b0;
  endtask

  task automatic wait_not_busy;
    int cnt = 0;
    @(negedge clk);
    while (busy === 1'b1 && cnt < 600) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL busy_release: busy=%b after %0d cycles, required 0", busy, cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic exp_busy;
    rst_n = 1'b0;
    set_idle();
    r0_valid = 1'b1; r1_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({r0_ready, r1_ready} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_ready: got %b required 00", {r0_ready, r1_ready});
    end
    n_checks++;
    if ({busy, ram_csb0} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL reset_busy_csb: got %b required 11", {busy, ram_csb0});
    end
    repeat (2) @(posedge clk);
    n_checks++;
    if ({r0_rsp_valid, r1_rsp_valid} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_rsp_valid: got %b required 00", {r0_rsp_valid, r1_rsp_valid});
    end
    #1;
    rst_n = 1'b1;
    set_idle();
    @(negedge clk);
`ifdef SRAM_ARB_CLEAR_ON_RESET_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif
    n_checks++;
    if (busy !== exp_busy) begin
      n_fail++;
      $display("[TB] FAIL busy_after_release: got %b required %b", busy, exp_busy);
    end
    @(posedge clk); #1;
    wait_not_busy();
  endtask

  task automatic test_write_read;
    r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 9'd5; r0_wmask = 4'hF; r0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if (r0_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wr_ready: got %b required 1", r0_ready);
    end
    n_checks++;
    if ({ram_csb0, ram_web0, ram_wmask0, ram_addr0} !== {2'b00, 4'hF, 9'd5}) begin
      n_fail++;
      $display("[TB] FAIL wr_pins: got csb=%b web=%b mask=%h addr=%0d required 0 0 f 5",
               ram_csb0, ram_web0, ram_wmask0, ram_addr0);
    end
    n_checks++;
    if (ram_din0 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("[TB] FAIL wr_din: got %h required deadbeef", ram_din0);
    end
    @(posedge clk); #1;
    r0_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({r0_ready, ram_csb0, ram_web0, ram_wmask0} !== 7'b1_0_1_0000) begin
      n_fail++;
      $display("[TB] FAIL rd_pins: got ready=%b csb=%b web=%b mask=%h required 1 0 1 0",
               r0_ready, ram_csb0, ram_web0, ram_wmask0);
    end
    n_checks++;
    if (r0_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wr_no_rsp: got %b required 0", r0_rsp_valid);
    end
    @(posedge clk); #1;
    r0_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({r0_rsp_valid, r0_rsp_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      n_fail++;
      $display("[TB] FAIL rd_rsp: got valid=%b data=%h required 1 deadbeef", r0_rsp_valid, r0_rsp_rdata);
    end
    n_checks++;
    if ({r1_rsp_valid, r1_rsp_rdata} !== 33'd0) begin
      n_fail++;
      $display("[TB] FAIL rd_rsp_other: got valid=%b data=%h required 0 0", r1_rsp_valid, r1_rsp_rdata);
    end
    n_checks++;
    if ({ram_csb0, ram_web0, ram_addr0} !== {1'b1, 1'b0, 9'd0}) begin
      n_fail++;
      $display("[TB] FAIL idle_pins: got csb=%b web=%b addr=%0d required 1 0 0", ram_csb0, ram_web0, ram_addr0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({r0_rsp_valid, r0_rsp_rdata} !== 33'd0) begin
      n_fail++;
      $display("[TB] FAIL rsp_clear: got valid=%b data=%h required 0 0", r0_rsp_valid, r0_rsp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_mask;
    r0_cycle(1'b1, 9'd7, 4'hF, 32'h11223344);
    r0_cycle(1'b1, 9'd7, 4'b0100, 32'hAABBCCDD);
    r0_cycle(1'b0, 9'd7, 4'hF, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({r0_rsp_valid, r0_rsp_rdata} !== {1'b1, 32'h11BB3344}) begin
      n_fail++;
      $display("[TB] FAIL mask_merge: got valid=%b data=%h required 1 11bb3344", r0_rsp_valid, r0_rsp_rdata);
    end
    @(posedge clk); #1;
    // A zero-mask write must still be accepted but leave the word untouched.
    r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 9'd7; r0_wmask = 4'h0; r0_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    n_checks++;
    if ({r0_ready, ram_csb0, ram_web0, ram_wmask0} !== 7'b1_0_0_0000) begin
      n_fail++;
      $display("[TB] FAIL zero_mask_issue: got ready=%b csb=%b web=%b mask=%h required 1 0 0 0",
               r0_ready, ram_csb0, ram_web0, ram_wmask0);
    end
    @(posedge clk); #1;
    r0_cycle(1'b0, 9'd7, 4'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({r0_rsp_valid, r0_rsp_rdata} !== {1'b1, 32'h11BB3344}) begin
      n_fail++;
      $display("[TB] FAIL zero_mask_data: got valid=%b data=%h required 1 11bb3344", r0_rsp_valid, r0_rsp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin;
    logic [31:0] exp0, exp1;
    logic        owner;
`ifdef SRAM_ARB_CLEAR_ON_RESET_EN
    exp0 = 32'h0; exp1 = 32'h0;
`else
    exp0 = 32'hC0DE0014; exp1 = 32'hC0DE0015;
`endif
    rst_n = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_not_busy();
    for (int k = 0; k < 5; k++) begin
      r0_valid = (k < 4); r0_we = 1'b0; r0_addr = 9'd20;
      r1_valid = (k < 4); r1_we = 1'b0; r1_addr = 9'd21;
      @(negedge clk);
      if (k < 4) begin
        n_checks++;
        if ({r0_ready, r1_ready} !== {(k % 2 == 0), (k % 2 == 1)}) begin
          n_fail++;
          $display("[TB] FAIL rr_grant[%0d]: got r0=%b r1=%b required r0=%b", k, r0_ready, r1_ready, (k % 2 == 0));
        end
      end
      if (k > 0) begin
        owner = ((k - 1) % 2 == 1);
        n_checks++;
        if ({r0_rsp_valid, r1_rsp_valid} !== {!owner, owner}) begin
          n_fail++;
          $display("[TB] FAIL rr_route[%0d]: got r0=%b r1=%b required r0=%b r1=%b",
                   k, r0_rsp_valid, r1_rsp_valid, !owner, owner);
        end
        n_checks++;
        if ((owner ? r1_rsp_rdata : r0_rsp_rdata) !== (owner ? exp1 : exp0)) begin
          n_fail++;
          $display("[TB] FAIL rr_data[%0d]: got %h required %h",
                   k, owner ? r1_rsp_rdata : r0_rsp_rdata, owner ? exp1 : exp0);
        end
      end
      @(posedge clk); #1;
    end
    set_idle();
  endtask

  task automatic test_only_r1;
    for (int j = 0; j < 3; j++) begin
      r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 9'd30 + 9'(j);
      @(negedge clk);
      n_checks++;
      if ({r0_ready, r1_ready, ram_addr0} !== {2'b01, 9'd30 + 9'(j)}) begin
        n_fail++;
        $display("[TB] FAIL only_r1[%0d]: got r0=%b r1=%b addr=%0d required 0 1 %0d",
                 j, r0_ready, r1_ready, ram_addr0, 30 + j);
      end
      @(posedge clk); #1;
    end
    r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 9'd40;
    @(negedge clk);
    n_checks++;
    if ({r0_ready, r1_ready, ram_addr0} !== {2'b10, 9'd40}) begin
      n_fail++;
      $display("[TB] FAIL tie_after_r1: got r0=%b r1=%b addr=%0d required 1 0 40", r0_ready, r1_ready, ram_addr0);
    end
    @(posedge clk); #1;
    set_idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 9'd5;
    @(negedge clk);
    n_checks++;
    if (r0_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_issue: got %b required 1", r0_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_idle();
    @(negedge clk);
    n_checks++;
    if ({r0_rsp_valid, r1_rsp_valid} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL mid_drop: got %b required 00", {r0_rsp_valid, r1_rsp_valid});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_not_busy();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_checks++;
      if ({r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid} !== 4'b0000) begin
        n_fail++;
        $display("[TB] FAIL mid_quiet[%0d]: got %b required 0000", j,
                 {r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid});
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef SRAM_ARB_CLEAR_ON_RESET_EN
  task automatic test_clear;
    int busy_cycles = 0;
    int ready_err = 0;
    r0_cycle(1'b1, 9'd511, 4'hF, 32'h12345678);
    rst_n = 1'b0;
    r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 9'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    while (busy === 1'b1 && busy_cycles < 600) begin
      busy_cycles++;
      if ({r0_ready, r1_ready} !== 2'b00) ready_err++;
      @(negedge clk);
    end
    n_checks++;
    if (busy_cycles != 512) begin
      n_fail++;
      $display("[TB] FAIL clear_len: got %0d busy cycles required 512", busy_cycles);
    end
    n_checks++;
    if (ready_err != 0) begin
      n_fail++;
      $display("[TB] FAIL clear_ready: got %0d cycles with ready high required 0", ready_err);
    end
    n_checks++;
    if (r0_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL clear_done_ready: got %b required 1", r0_ready);
    end
    @(posedge clk); #1;
    r0_addr = 9'd511;
    @(negedge clk);
    n_checks++;
    if ({r0_rsp_valid, r0_rsp_rdata} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("[TB] FAIL clear_addr0: got valid=%b data=%h required 1 0", r0_rsp_valid, r0_rsp_rdata);
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if ({r0_rsp_valid, r0_rsp_rdata} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("[TB] FAIL clear_addr511: got valid=%b data=%h required 1 0", r0_rsp_valid, r0_rsp_rdata);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_round_robin();
    test_only_r1();
    test_reset_mid();
`ifdef SRAM_ARB_CLEAR_ON_RESET_EN
    test_clear();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
